// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// The requester drives the byte and the request. The transmitter returns
// its ready/busy state and the one-cycle done/error outcome pulses.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  // Requester side: offers a byte and observes the outcome
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  tx_done,
    input  tx_error
  );

  // Transmitter side: accepts a byte and reports the outcome
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard.
// The host first inhibits the bus by holding CLK low. It then pulls DATA low
// as the start bit and releases CLK. The device then generates the clock.
// The host moves DATA on each falling edge of that clock: 8 data bits (LSB
// first), odd parity, then the stop bit. On the 11th falling edge the host
// samples the device's ack, then waits for both lines to return high.
// The pins are open-drain, so *_oe = 1 pulls the line low.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic              clk,
  input  logic              reset_n,
  ps2_host_tx_if.slave      txIf,
  input  logic              ps2_clk_async,
  input  logic              ps2_data_async,
  output logic              ps2_clk_oe,
  output logic              ps2_data_oe
);

  // One counter covers both the inhibit phase and the ack timeout. It is
  // sized for the larger of the two limits.
  localparam int MaxCycles = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);

  // The last inhibit cycle, and the cycle before it. DATA must already be
  // pulled low during the last cycle of the inhibit phase.
  localparam int InhLastInt = (INHIBIT_CYCLES >= 1) ? INHIBIT_CYCLES - 1 : 0;
  localparam int InhPreInt  = (INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0;
  localparam int ToLastInt  = (TIMEOUT_CYCLES >= 1) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [CntW-1:0] InhLast = CntW'(InhLastInt);
  localparam logic [CntW-1:0] InhPre  = CntW'(InhPreInt);
  localparam logic [CntW-1:0] ToLast  = CntW'(ToLastInt);
  localparam logic [CntW-1:0] CntMax  = '1;

  // With a one-cycle inhibit, DATA must go low on the same edge as CLK.
  localparam logic InhOneCycle = (INHIBIT_CYCLES <= 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StAck,
    StWaitIdle
  } state_t;

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      bitIdx_q;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic            ready_q;
  logic            done_q;
  logic            err_q;
  logic            clkOe_q;
  logic            dataOe_q;

  logic [2:0]      clkSync_q;
  logic [1:0]      dataSync_q;

  logic            clkFall;
  logic            clkSync;
  logic            dataSync;

  // Bring the raw pins into the clock domain. CLK gets a third stage so a
  // falling edge can be seen. Both reset high because idle lines float high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clkSync_q  <= 3'b111;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[1:0], ps2_clk_async};
      dataSync_q <= {dataSync_q[0], ps2_data_async};
    end
  end

  assign clkSync  = clkSync_q[1];
  assign dataSync = dataSync_q[1];
  assign clkFall  = clkSync_q[2] & ~clkSync_q[1];

  // Transfer sequencer. All handshake outputs and pin enables are registered.
  // Done and error come from mutually exclusive branches, so they never pulse
  // together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      clkOe_q  <= 1'b0;
      dataOe_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          clkOe_q  <= 1'b0;
          dataOe_q <= 1'b0;
          if (txIf.tx_valid && ready_q) begin
            shift_q  <= txIf.tx_data;
            parity_q <= ~^txIf.tx_data;
            ready_q  <= 1'b0;
            clkOe_q  <= 1'b1;
            dataOe_q <= InhOneCycle;
            cnt_q    <= '0;
            state_q  <= StInhibit;
          end
        end

        StInhibit: begin
          if (cnt_q == InhLast) begin
            clkOe_q  <= 1'b0;
            dataOe_q <= 1'b1;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            state_q  <= StReq;
          end else begin
            cnt_q <= (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
            if (cnt_q == InhPre) begin
              dataOe_q <= 1'b1;
            end
          end
        end

        StReq, StAck, StWaitIdle: begin
          if (cnt_q == ToLast) begin
            err_q    <= 1'b1;
            ready_q  <= 1'b1;
            clkOe_q  <= 1'b0;
            dataOe_q <= 1'b0;
            state_q  <= StIdle;
          end else begin
            cnt_q <= (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
            case (state_q)
              StReq: begin
                if (clkFall) begin
                  if (bitIdx_q < 4'd8) begin
                    dataOe_q <= ~shift_q[bitIdx_q[2:0]];
                  end else if (bitIdx_q == 4'd8) begin
                    dataOe_q <= ~parity_q;
                  end else begin
                    dataOe_q <= 1'b0;
                    state_q  <= StAck;
                  end
                  bitIdx_q <= bitIdx_q + 1'b1;
                end
              end

              StAck: begin
                if (clkFall) begin
                  if (!dataSync) begin
                    state_q <= StWaitIdle;
                  end else begin
                    err_q    <= 1'b1;
                    ready_q  <= 1'b1;
                    clkOe_q  <= 1'b0;
                    dataOe_q <= 1'b0;
                    state_q  <= StIdle;
                  end
                end
              end

              default: begin
                if (clkSync && dataSync) begin
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= StIdle;
                end
              end
            endcase
          end
        end

        default: begin
          ready_q  <= 1'b1;
          clkOe_q  <= 1'b0;
          dataOe_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign txIf.tx_ready = ready_q;
  assign txIf.busy     = ~ready_q;
  assign txIf.tx_done  = done_q;
  assign txIf.tx_error = err_q;
  assign ps2_clk_oe    = clkOe_q;
  assign ps2_data_oe   = dataOe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for the PS/2 host transmitter.
// A behavioural keyboard model clocks the bus and samples every frame bit.
// Expected frames are queued when a byte is offered and compared when the
// model finishes sampling.
module tb_ps2_host_tx;
  localparam int InhibitCycles = 20;
  localparam int TimeoutCycles = 2000;
  localparam int HalfPeriod    = 40;

  typedef logic [10:0] frame_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2ClkOe;
  logic ps2DataOe;
  logic bfmClkLow = 1'b0;
  logic bfmDataLow = 1'b0;
  logic ps2ClkLine;
  logic ps2DataLine;

  int errors = 0;
  int checks = 0;
  int doneCount = 0;
  int errorCount = 0;
  int overlapCount = 0;
  int longPulseCount = 0;
  logic prevDone = 1'b0;
  logic prevErr = 1'b0;

  frame_t expQ[$];

  ps2_host_tx_if txIf();

  // Open-drain wires with pull-ups: a line is low if either side pulls it
  assign ps2ClkLine  = ~(ps2ClkOe | bfmClkLow);
  assign ps2DataLine = ~(ps2DataOe | bfmDataLow);

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhibitCycles),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .txIf          (txIf),
    .ps2_clk_async (ps2ClkLine),
    .ps2_data_async(ps2DataLine),
    .ps2_clk_oe    (ps2ClkOe),
    .ps2_data_oe   (ps2DataOe)
  );

  // 100 MHz-style bench clock; the absolute period does not matter here
  always #5 clk = ~clk;

  // Count the outcome pulses and note any that overlap or last more than one cycle
  always @(negedge clk) begin
    if (txIf.tx_done === 1'b1) doneCount++;
    if (txIf.tx_error === 1'b1) errorCount++;
    if (txIf.tx_done === 1'b1 && txIf.tx_error === 1'b1) overlapCount++;
    if ((txIf.tx_done === 1'b1 && prevDone) || (txIf.tx_error === 1'b1 && prevErr)) longPulseCount++;
    prevDone = (txIf.tx_done === 1'b1);
    prevErr  = (txIf.tx_error === 1'b1);
  end

  // Reference frame: start 0, data LSB first, odd parity, stop 1
  function automatic frame_t makeFrame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // Offer one byte, queue its expected frame and hold the request until it is taken
  task automatic applyStimulus(input logic [7:0] d);
    int n;
    @(negedge clk);
    txIf.tx_data  = d;
    txIf.tx_valid = 1'b1;
    expQ.push_back(makeFrame(d));
    n = 0;
    while (txIf.tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    txIf.tx_valid = 1'b0;
    checks++;
    if (txIf.tx_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL accept_%02h: tx_ready=%b required 0", d, txIf.tx_ready);
    end
  endtask

  // Measure how long CLK stays pulled low and sample DATA in the first and last inhibit cycles
  task automatic waitInhibit(output int highCycles, output logic firstDataOe, output logic lastDataOe);
    highCycles  = 0;
    firstDataOe = 1'bx;
    lastDataOe  = 1'bx;
    while (ps2ClkOe === 1'b1 && highCycles < 1000) begin
      if (highCycles == 0) firstDataOe = ps2DataOe;
      lastDataOe = ps2DataOe;
      highCycles++;
      @(negedge clk);
    end
  endtask

  // Keyboard model: clock up to nFalls falling edges and sample DATA in each low phase
  task automatic bfmRun(input int nFalls, input logic giveAck, output frame_t got);
    frame_t exp;
    frame_t mask;
    got = '0;
    exp = '0;
    if (expQ.size() > 0) exp = expQ.pop_front();
    mask = (nFalls >= 10) ? 11'h7FF : frame_t'((11'd1 << (nFalls + 1)) - 11'd1);
    repeat (10) @(negedge clk);
    got[0] = ps2DataLine;
    for (int k = 1; k <= nFalls && k <= 10; k++) begin
      bfmClkLow = 1'b1;
      repeat (HalfPeriod) @(negedge clk);
      got[k] = ps2DataLine;
      bfmClkLow = 1'b0;
      repeat (HalfPeriod) @(negedge clk);
    end
    if (nFalls >= 11) begin
      bfmDataLow = giveAck;
      repeat (5) @(negedge clk);
      bfmClkLow = 1'b1;
      repeat (HalfPeriod) @(negedge clk);
      bfmClkLow = 1'b0;
      repeat (10) @(negedge clk);
      bfmDataLow = 1'b0;
    end
    checks++;
    if ((got & mask) !== (exp & mask)) begin
      errors++;
      $display("[TB] FAIL frame: sampled=%b required=%b (mask %b)", got, exp, mask);
    end
  endtask

  // Wait, with a bound, for the done or error pulse
  task automatic waitPulse(input int budget);
    int n;
    n = 0;
    while (txIf.tx_done !== 1'b1 && txIf.tx_error !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL pulse_wait: no outcome pulse within %0d cycles", budget);
    end
    repeat (3) @(negedge clk);
  endtask

  // Send one byte through a complete transfer and check its outcome
  task automatic fullTransfer(input logic [7:0] d, output frame_t got);
    int hc;
    logic f0, f1;
    int d0;
    d0 = doneCount;
    applyStimulus(d);
    waitInhibit(hc, f0, f1);
    bfmRun(11, 1'b1, got);
    waitPulse(500);
    checks++;
    if (doneCount - d0 !== 1) begin
      errors++;
      $display("[TB] FAIL done_%02h: done pulses=%0d required 1", d, doneCount - d0);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (txIf.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: %b required 1", txIf.tx_ready); end
    if (txIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: %b required 0", txIf.busy); end
    if (txIf.tx_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: %b required 0", txIf.tx_done); end
    if (txIf.tx_error !== 1'b0) begin errors++; $display("[TB] FAIL rst_error: %b required 0", txIf.tx_error); end
    if (ps2ClkOe !== 1'b0) begin errors++; $display("[TB] FAIL rst_clk_oe: %b required 0", ps2ClkOe); end
    if (ps2DataOe !== 1'b0) begin errors++; $display("[TB] FAIL rst_data_oe: %b required 0", ps2DataOe); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_ed();
    int hc;
    logic f0, f1;
    frame_t got;
    int d0, e0;
    d0 = doneCount;
    e0 = errorCount;
    applyStimulus(8'hED);
    waitInhibit(hc, f0, f1);
    checks += 5;
    if (hc !== InhibitCycles) begin errors++; $display("[TB] FAIL inhibit_len: %0d cycles required %0d", hc, InhibitCycles); end
    if (f0 !== 1'b0) begin errors++; $display("[TB] FAIL inhibit_data_first: data_oe=%b required 0", f0); end
    if (f1 !== 1'b1) begin errors++; $display("[TB] FAIL inhibit_data_last: data_oe=%b required 1", f1); end
    if (ps2DataOe !== 1'b1) begin errors++; $display("[TB] FAIL req_start: data_oe=%b required 1", ps2DataOe); end
    if (txIf.busy !== 1'b1) begin errors++; $display("[TB] FAIL req_busy: %b required 1", txIf.busy); end
    bfmRun(11, 1'b1, got);
    checks++;
    if (got !== 11'b111_1101_1010) begin errors++; $display("[TB] FAIL ed_bits: %b required 11111011010", got); end
    waitPulse(500);
    checks += 4;
    if (doneCount - d0 !== 1) begin errors++; $display("[TB] FAIL ed_done: pulses=%0d required 1", doneCount - d0); end
    if (errorCount - e0 !== 0) begin errors++; $display("[TB] FAIL ed_error: pulses=%0d required 0", errorCount - e0); end
    if (txIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL ed_busy: %b required 0", txIf.busy); end
    if (txIf.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL ed_ready: %b required 1", txIf.tx_ready); end
  endtask

  task automatic test_parity();
    logic [7:0] bytes [3] = '{8'h01, 8'hFF, 8'h00};
    logic       par   [3] = '{1'b0, 1'b1, 1'b1};
    frame_t got;
    for (int i = 0; i < 3; i++) begin
      fullTransfer(bytes[i], got);
      checks++;
      if (got[9] !== par[i]) begin
        errors++;
        $display("[TB] FAIL parity_%02h: parity=%b required %b", bytes[i], got[9], par[i]);
      end
    end
  endtask

  task automatic test_no_ack();
    int hc;
    logic f0, f1;
    frame_t got;
    int d0, e0;
    d0 = doneCount;
    e0 = errorCount;
    applyStimulus(8'h12);
    waitInhibit(hc, f0, f1);
    bfmRun(11, 1'b0, got);
    repeat (20) @(negedge clk);
    checks += 5;
    if (errorCount - e0 !== 1) begin errors++; $display("[TB] FAIL noack_error: pulses=%0d required 1", errorCount - e0); end
    if (doneCount - d0 !== 0) begin errors++; $display("[TB] FAIL noack_done: pulses=%0d required 0", doneCount - d0); end
    if (ps2ClkOe !== 1'b0) begin errors++; $display("[TB] FAIL noack_clk_oe: %b required 0", ps2ClkOe); end
    if (ps2DataOe !== 1'b0) begin errors++; $display("[TB] FAIL noack_data_oe: %b required 0", ps2DataOe); end
    if (txIf.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL noack_ready: %b required 1", txIf.tx_ready); end
  endtask

  task automatic test_timeout();
    int hc;
    logic f0, f1;
    int n;
    applyStimulus(8'hAB);
    waitInhibit(hc, f0, f1);
    void'(expQ.pop_front());
    n = 0;
    while (txIf.tx_error !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== TimeoutCycles) begin errors++; $display("[TB] FAIL timeout_len: %0d cycles required %0d", n, TimeoutCycles); end
    @(negedge clk);
    checks += 3;
    if (ps2ClkOe !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clk_oe: %b required 0", ps2ClkOe); end
    if (ps2DataOe !== 1'b0) begin errors++; $display("[TB] FAIL timeout_data_oe: %b required 0", ps2DataOe); end
    if (txIf.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL timeout_ready: %b required 1", txIf.tx_ready); end
  endtask

  task automatic test_back_to_back();
    int hc;
    logic f0, f1;
    frame_t got;
    int d0;
    d0 = doneCount;
    applyStimulus(8'h3C);
    waitInhibit(hc, f0, f1);
    fork
      bfmRun(11, 1'b1, got);
      begin
        repeat (200) @(negedge clk);
        txIf.tx_data  = 8'h55;
        txIf.tx_valid = 1'b1;
        @(negedge clk);
        txIf.tx_valid = 1'b0;
      end
    join
    waitPulse(500);
    repeat (100) @(negedge clk);
    checks += 2;
    if (doneCount - d0 !== 1) begin errors++; $display("[TB] FAIL ignore_done: pulses=%0d required 1", doneCount - d0); end
    if (ps2ClkOe !== 1'b0) begin errors++; $display("[TB] FAIL ignore_restart: clk_oe=%b required 0", ps2ClkOe); end
  endtask

  task automatic test_reset_mid();
    int hc;
    logic f0, f1;
    frame_t got;
    int d0, e0;
    applyStimulus(8'h92);
    waitInhibit(hc, f0, f1);
    bfmRun(4, 1'b0, got);
    checks++;
    if (ps2DataOe !== 1'b1) begin errors++; $display("[TB] FAIL mid_bit3: data_oe=%b required 1", ps2DataOe); end
    d0 = doneCount;
    e0 = errorCount;
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (ps2ClkOe !== 1'b0) begin errors++; $display("[TB] FAIL mid_clk_oe: %b required 0", ps2ClkOe); end
    if (ps2DataOe !== 1'b0) begin errors++; $display("[TB] FAIL mid_data_oe: %b required 0", ps2DataOe); end
    if (txIf.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready: %b required 1", txIf.tx_ready); end
    if (txIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: %b required 0", txIf.busy); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if ((doneCount - d0) + (errorCount - e0) !== 0) begin
      errors++;
      $display("[TB] FAIL mid_pulses: %0d pulses required 0", (doneCount - d0) + (errorCount - e0));
    end
    fullTransfer(8'hF4, got);
  endtask

  task automatic test_pulse_shape();
    checks += 2;
    if (overlapCount !== 0) begin errors++; $display("[TB] FAIL pulse_overlap: %0d required 0", overlapCount); end
    if (longPulseCount !== 0) begin errors++; $display("[TB] FAIL pulse_width: %0d long pulses required 0", longPulseCount); end
  endtask

  // Run every scenario in order, then report
  initial begin
    txIf.tx_data  = 8'h00;
    txIf.tx_valid = 1'b0;
    test_reset();
    test_basic_ed();
    test_parity();
    test_no_ack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_pulse_shape();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a scenario wedges
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
